// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode stage with an integrated register file. It captures an
// instruction word from fetch, reads its operands (with same-cycle write-back
// bypass), and presents op/a/b/imm/dest/dest_wr from one output register.
// A busy bit per register tracks writes that are still in flight. An
// instruction whose sources, or whose destination, are still pending is held
// back (RAW/WAW hazard).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_valid/in_ready move ir_i into the stage. out_valid/out_ready
// move the output register into execute. A producer must not drop valid or
// change its payload until the transfer. Ready may depend combinationally on
// valid and on the payload (in_ready depends on ir_i through the hazard check).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    fetch-side handshake
//   ir_i[31:0]            instruction: op[31:26] Ri[25:21] Rj[20:16] Rk[15:11]
//   out_valid, out_ready  execute-side handshake
//   op, a, b, imm         decoded opcode and operands
//   dest, dest_wr         destination register and its write flag
//   wb_en, wb_addr, wb_data  register write-back port
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int  DATA_W   = 32,
   parameter int  NREG     = 32,
   parameter int  ZERO_REG = 1,
   parameter int  SEXT_IMM = 0,
   localparam int AW       = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       ir_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        op,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] imm,
   output logic [AW-1:0]     dest,
   output logic              dest_wr,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   localparam bit ZERO_EN = (ZERO_REG != 0);
   localparam bit SEXT_EN = (SEXT_IMM != 0);

   // ---------------------------------------------------------------- state
   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_n;

   // ---------------------------------------------------------------- decode
   logic [5:0]    op_d;
   logic [AW-1:0] ri, rj, rk;
   logic          is_alu, is_ld, is_st, is_beq, is_jmp;
   logic          rd_ri, rd_rj, rd_rk, wr_ri;

   assign op_d = ir_i[31:26];
   assign ri   = ir_i[21 +: AW];
   assign rj   = ir_i[16 +: AW];
   assign rk   = ir_i[11 +: AW];

   assign is_alu = (op_d[5:4] == 2'b00);
   assign is_ld  = (op_d[5:4] == 2'b01) && !op_d[0];
   assign is_st  = (op_d[5:4] == 2'b01) &&  op_d[0];
   assign is_beq = (op_d == 6'b100000);
   assign is_jmp = (op_d == 6'b100001);

   assign rd_ri = is_st || is_beq;
   assign rd_rj = !is_jmp;
   assign rd_rk = is_alu;
   assign wr_ri = is_alu || is_ld;

   // ---------------------------------------------------------- read ports
   // Port 0 = Ri, 1 = Rj, 2 = Rk. Each read sees write-back data in the same
   // cycle, and a register being written back this cycle no longer counts as
   // busy, so a stalled reader is released in the write-back cycle itself.
   logic [AW-1:0]     rd_addr [3];
   logic [DATA_W-1:0] rd_val  [3];
   logic [2:0]        rd_busy;
   logic [2:0]        rd_used;

   assign rd_addr[0] = ri;
   assign rd_addr[1] = rj;
   assign rd_addr[2] = rk;

   for (genvar p = 0; p < 3; p++) begin : g_rd
      logic is_zero;
      logic wb_hit;
      assign is_zero    = ZERO_EN && (rd_addr[p] == '0);
      assign wb_hit     = wb_en && (wb_addr == rd_addr[p]);
      assign rd_val[p]  = is_zero ? '0 : (wb_hit ? wb_data : regs[rd_addr[p]]);
      assign rd_busy[p] = busy[rd_addr[p]] && !wb_hit;
   end

   // Ri is checked both when it is a source and when it is the destination
   // (the latter catches WAW).
   assign rd_used = {rd_rk, rd_rj, rd_ri || wr_ri};

   logic hazard;
   logic accept;

   assign hazard   = |(rd_used & rd_busy);
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------ operands
   logic [DATA_W-1:0] a_n, b_n, imm_n;
   logic              sext_bit;

   assign a_n = is_jmp ? '0 : (is_beq ? (rd_val[0] ^ rd_val[1]) : rd_val[1]);
   assign b_n = is_alu ? rd_val[2] : rd_val[0];

   // JMP takes a 26-bit zero-extended target. Everything else takes ir[15:0],
   // extended by sign or zero. Built bit by bit so any DATA_W truncates cleanly.
   assign sext_bit = SEXT_EN && ir_i[15];

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm
      if (gi < 16) begin : g_lo
         assign imm_n[gi] = ir_i[gi];
      end else if (gi < 26) begin : g_mid
         assign imm_n[gi] = is_jmp ? ir_i[gi] : sext_bit;
      end else begin : g_hi
         assign imm_n[gi] = is_jmp ? 1'b0 : sext_bit;
      end
   end

   // ---------------------------------------------------------- scoreboard
   // Clear from write-back first, then set from accept, so a set and a clear
   // of the same register in one cycle leave it busy.
   always_comb begin
      busy_n = busy;
      if (wb_en) begin
         busy_n[wb_addr] = 1'b0;
      end
      if (accept && wr_ri && !(ZERO_EN && (ri == '0))) begin
         busy_n[ri] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_n;
      end
   end

   // ------------------------------------------------------- register file
   logic wb_wr;
   assign wb_wr = wb_en && !(ZERO_EN && (wb_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_wr) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // ----------------------------------------------------- output register
   // Operands are captured at accept time, so later write-backs to the
   // source registers cannot disturb an instruction held under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         op        <= '0;
         a         <= '0;
         b         <= '0;
         imm       <= '0;
         dest      <= '0;
         dest_wr   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         op        <= op_d;
         a         <= a_n;
         b         <= b_n;
         imm       <= imm_n;
         dest      <= ri;
         dest_wr   <= wr_ri;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
